ssd_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display. It owns the single hex-to-segment decoder instance in the display path and shares it among `NUM_DIGITS` digits. Each digit gets a fixed-length slot with a ghosting guard interval, and display updates are double-buffered so a new value is only shown at a frame boundary. It sits between the counter datapath (which supplies packed BCD/hex nibbles) and the board pins; its `dig` output feeds the decoder's 4-bit input.

---
 rtl/ssd_scan_ctrl_if.sv | 25 ++
 rtl/ssd_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ssd_scan_ctrl_if.sv
// Display-side bundle of the seven-segment scan controller: frame data and
// control in from the datapath, decoder nibble and pin drives out.
interface ssd_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    lz_en;
    logic                    load;
    logic [3:0]              dig;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    dp;
    logic                    frame_start;

    modport master (
        output value, dp_in, digit_en, lz_en, load,
        input  dig, anode, dp, frame_start
    );

    modport slave (
        input  value, dp_in, digit_en, lz_en, load,
        output dig, anode, dp, frame_start
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display,
// with per-slot ghosting guard and frame-aligned double buffering.
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input logic          clk,
    input logic          rst_n,
    ssd_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    localparam logic [0:0] GUARD = 1'b0;
    localparam logic [0:0] DRIVE = 1'b1;

    logic [CW-1:0]         cnt, cnt_n;
    logic [IW-1:0]         idx, idx_n;
    logic [0:0]            state, state_n;
    logic [VW-1:0]         stage_val, stage_val_n, shadow_val, shadow_val_n;
    logic [NUM_DIGITS-1:0] stage_dp, stage_dp_n, shadow_dp, shadow_dp_n;
    logic                  pending, pending_n;
    logic                  wrap_slot, wrap_frame;

    logic [3:0]            dig_q, dig_n;
    logic [NUM_DIGITS-1:0] anode_q, anode_n;
    logic                  dp_q, dp_n;
    logic                  frame_start_q;
    logic                  zero_above, blank;

    always_comb begin
        wrap_slot  = (cnt == CNT_MAX);
        wrap_frame = wrap_slot && (idx == IDX_MAX);
        cnt_n      = wrap_slot ? '0 : cnt + CW'(1);
        idx_n      = idx;
        if (wrap_slot)
            idx_n = (idx == IDX_MAX) ? '0 : idx + IW'(1);
        state_n = state;
        if (wrap_slot)
            state_n = GUARD;
        else if (cnt_n == CNT_GUARD)
            state_n = DRIVE;

        stage_val_n  = stage_val;
        stage_dp_n   = stage_dp;
        shadow_val_n = shadow_val;
        shadow_dp_n  = shadow_dp;
        pending_n    = pending;
        if (bus.load) begin
            stage_val_n = bus.value;
            stage_dp_n  = bus.dp_in;
            pending_n   = 1'b1;
        end
        // A load coinciding with the wrap bypasses staging straight to the shadow.
        if (wrap_frame) begin
            if (bus.load) begin
                shadow_val_n = bus.value;
                shadow_dp_n  = bus.dp_in;
                pending_n    = 1'b0;
            end else if (pending) begin
                shadow_val_n = stage_val;
                shadow_dp_n  = stage_dp;
                pending_n    = 1'b0;
            end
        end
    end

    // Outputs are computed from next-state values so the registered pins line
    // up with the registered cnt/idx in the same cycle.
    always_comb begin
        zero_above = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i >= 32'(idx_n) && shadow_val_n[4*i +: 4] != 4'h0)
                zero_above = 1'b0;
        end
        blank   = !bus.digit_en[idx_n] || (bus.lz_en && (idx_n != '0) && zero_above);
        anode_n = '1;
        if (state_n == DRIVE && !blank)
            anode_n[idx_n] = 1'b0;
        dp_n  = (state_n == DRIVE) && !blank && shadow_dp_n[idx_n];
        dig_n = shadow_val_n[4*idx_n +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= '0;
            idx           <= '0;
            state         <= GUARD;
            stage_val     <= '0;
            stage_dp      <= '0;
            shadow_val    <= '0;
            shadow_dp     <= '0;
            pending       <= 1'b0;
            dig_q         <= '0;
            anode_q       <= '1;
            dp_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt           <= cnt_n;
            idx           <= idx_n;
            state         <= state_n;
            stage_val     <= stage_val_n;
            stage_dp      <= stage_dp_n;
            shadow_val    <= shadow_val_n;
            shadow_dp     <= shadow_dp_n;
            pending       <= pending_n;
            dig_q         <= dig_n;
            anode_q       <= anode_n;
            dp_q          <= dp_n;
            frame_start_q <= wrap_frame;
        end
    end

    assign bus.dig         = dig_q;
    assign bus.anode       = anode_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl at 4 digits, 8-cycle slots, 2-cycle guard:
// per-frame expectation table plus boundary-load and mid-run-reset sequences.
module tb_ssd_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ssd_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    ssd_scan_ctrl #(
        .NUM_DIGITS(4),
        .REFRESH_DIV(8),
        .GUARD_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // anode/dig hold one nibble per slot, slot 0 in bits [3:0].
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic [3:0]  en;
        logic        lz;
        logic [15:0] anode;
        logic [15:0] dig;
        logic [3:0]  dp;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] an, input logic [3:0] dg,
                                 input logic d, input logic fs);
        chk($sformatf("%s anode", tag), 16'(bus.anode), 16'(an));
        chk($sformatf("%s dig", tag), 16'(bus.dig), 16'(dg));
        chk($sformatf("%s dp", tag), 16'(bus.dp), 16'(d));
        chk($sformatf("%s frame_start", tag), 16'(bus.frame_start), 16'(fs));
    endtask

    // Starts at slot 0 / cnt 0 and checks every cycle of one frame.
    task automatic check_frame(input int id, input vec_t cur, input bit first,
                               input bit do_load, input vec_t nxt);
        for (int k = 0; k < 32; k++) begin
            int s;
            int c;
            logic [3:0] an_e;
            logic [3:0] dp_e;
            s = k / 8;
            c = k % 8;
            dp_e = cur.dp;
            an_e = (c < 2) ? 4'hF : cur.anode[4*s +: 4];
            check_outputs($sformatf("frame%0d k%0d", id, k), an_e, cur.dig[4*s +: 4],
                          (c < 2) ? 1'b0 : dp_e[s], (k == 0) && !first);
            bus.load = 1'b0;
            if (do_load && k == 6) begin
                bus.load  = 1'b1;
                bus.value = 16'hEEEE;
                bus.dp_in = 4'hF;
            end else if (do_load && k == 20) begin
                bus.load  = 1'b1;
                bus.value = nxt.value;
                bus.dp_in = nxt.dp_in;
            end
            if (do_load && k == 31) begin
                bus.digit_en = nxt.en;
                bus.lz_en    = nxt.lz;
            end
            tick();
        end
        bus.load = 1'b0;
    endtask

    initial begin
        tbl[0] = '{16'h0000, 4'b0000, 4'hF, 1'b0, 16'h7BDE, 16'h0000, 4'b0000};
        tbl[1] = '{16'h1234, 4'b0000, 4'hF, 1'b0, 16'h7BDE, 16'h1234, 4'b0000};
        tbl[2] = '{16'hABCD, 4'b0000, 4'hF, 1'b0, 16'h7BDE, 16'hABCD, 4'b0000};
        tbl[3] = '{16'h0050, 4'b0000, 4'hF, 1'b1, 16'hFFDE, 16'h0050, 4'b0000};
        tbl[4] = '{16'h0000, 4'b0000, 4'hF, 1'b1, 16'hFFFE, 16'h0000, 4'b0000};
        tbl[5] = '{16'h8421, 4'b0011, 4'b0101, 1'b0, 16'hFBFE, 16'h8421, 4'b0001};
        tbl[6] = '{16'h0F00, 4'b1111, 4'hF, 1'b1, 16'hFBDE, 16'h0F00, 4'b0111};

        bus.value    = '0;
        bus.dp_in    = '0;
        bus.digit_en = 4'hF;
        bus.lz_en    = 1'b0;
        bus.load     = 1'b0;

        repeat (3) tick();
        check_outputs("reset", 4'hF, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        check_frame(0, tbl[0], 1'b1, 1'b1, tbl[1]);
        for (int i = 1; i < 6; i++)
            check_frame(i, tbl[i], 1'b0, 1'b1, tbl[i+1]);
        check_frame(6, tbl[6], 1'b0, 1'b0, tbl[6]);

        // Load exactly on the wrap edge: visible in slot 0 of the new frame.
        repeat (31) tick();
        bus.load     = 1'b1;
        bus.value    = 16'h00F0;
        bus.dp_in    = 4'h0;
        bus.digit_en = 4'hF;
        bus.lz_en    = 1'b0;
        tick();
        bus.load = 1'b0;
        check_outputs("bload s0 guard", 4'hF, 4'h0, 1'b0, 1'b1);
        repeat (2) tick();
        check_outputs("bload s0 drive", 4'hE, 4'h0, 1'b0, 1'b0);
        repeat (8) tick();
        check_outputs("bload s1 drive", 4'hD, 4'hF, 1'b0, 1'b0);

        // Pending load in slot 1, reset during slot 2 drive discards it.
        bus.load  = 1'b1;
        bus.value = 16'h9999;
        bus.dp_in = 4'hF;
        tick();
        bus.load = 1'b0;
        repeat (8) tick();
        check_outputs("pre-reset s2 drive", 4'hB, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        check_outputs("midrun reset", 4'hF, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check_frame(7, tbl[0], 1'b1, 1'b0, tbl[0]);
        check_frame(8, tbl[0], 1'b0, 1'b0, tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
